// File: rtl/sprite_rom_if.sv
// Bundle between the sprite renderers, the shared sprite ROM and the arbiter.
// Handshake: a renderer holds req[i] (and optionally lock[i]) high until it
// sees gnt[i] in the same cycle; gnt[i] means req_addr slice i is on rom_addr
// at this rising edge. One cycle later rd_valid[i] qualifies rd_data for that
// renderer. There is no back-pressure, so every grant produces exactly one
// rd_valid pulse.
interface sprite_rom_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]       rom_addr;
    logic [DATA_W-1:0]       rom_q;
    logic [N_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]       rd_data;
    logic                    busy;
    logic                    fsm_state;

    // Renderer plus ROM side.
    modport master (
        output req, lock, req_addr, rom_q,
        input  gnt, rom_addr, rd_valid, rd_data, busy, fsm_state
    );

    // Arbiter side.
    modport slave (
        input  req, lock, req_addr, rom_q,
        output gnt, rom_addr, rd_valid, rd_data, busy, fsm_state
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port sprite ROM between N_REQ renderers. Round-robin
// arbitration with an optional burst lock: a granted renderer holding lock
// keeps the ROM until it drops req or lock. ROM read latency is one cycle.
module sprite_rom_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24
) (
    input logic             clk,
    input logic             reset,
    sprite_rom_if.slave     bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] last_ptr, last_ptr_nxt;
    logic [PTR_W-1:0] owner, owner_nxt;

    logic             rr_found;
    logic [PTR_W-1:0] rr_idx;
    logic             keep_lock;
    logic             grant_any;
    logic [PTR_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt_c;
    logic [ADDR_W-1:0] rom_addr_c;
    logic [N_REQ-1:0] rd_valid_q;

    // State register: FSM state, round-robin pointer and lock owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_ARB;
            last_ptr <= PTR_W'(N_REQ - 1);
            owner    <= '0;
        end else begin
            state    <= state_nxt;
            last_ptr <= last_ptr_nxt;
            owner    <= owner_nxt;
        end
    end

    // Round-robin search: first requester after last_ptr, wrapping to 0.
    always_comb begin
        int cand;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_ptr) + k) % N_REQ;
            if (!rr_found && bus.req[PTR_W'(cand)]) begin
                rr_found = 1'b1;
                rr_idx   = PTR_W'(cand);
            end
        end
    end

    // Next-state: the owner keeps the ROM while it holds req and lock;
    // otherwise arbitrate normally in the same cycle.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_ptr_nxt = last_ptr;
        keep_lock    = (state == ST_LOCKED) && bus.req[owner] && bus.lock[owner];
        grant_any    = keep_lock || rr_found;
        gnt_idx      = keep_lock ? owner : rr_idx;
        if (grant_any) begin
            last_ptr_nxt = gnt_idx;
        end
        if (keep_lock) begin
            state_nxt = ST_LOCKED;
        end else if (rr_found && bus.lock[rr_idx]) begin
            state_nxt = ST_LOCKED;
            owner_nxt = rr_idx;
        end else begin
            state_nxt = ST_ARB;
        end
    end

    // Outputs: one-hot grant and address mux, both forced to 0 during reset.
    always_comb begin
        gnt_c      = '0;
        rom_addr_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!reset && grant_any && (gnt_idx == PTR_W'(i))) begin
                gnt_c[i]   = 1'b1;
                rom_addr_c = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Read tag pipeline: the grant of this cycle marks next cycle's ROM word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= '0;
        end else begin
            rd_valid_q <= gnt_c;
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.rom_addr  = rom_addr_c;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = (!reset && (|rd_valid_q)) ? bus.rom_q : '0;
    assign bus.busy      = (state == ST_LOCKED);
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed scenarios followed by random
// req/lock/address traffic against a behavioural arbitration model and a
// ROM model with one cycle of read latency.
module tb_sprite_rom_arbiter;
    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 24;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sprite_rom_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ROM model: registered read, address sampled on the rising edge.
    logic [DW-1:0] rom_mem [256];
    always @(posedge clk) bus.rom_q <= rom_mem[bus.rom_addr];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    // Each entry: {granted one-hot, granted address} for the cycle it was issued.
    logic [N+AW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  m_last;
    bit  m_locked;
    int  m_owner;
    int  wait_cnt [N];

    logic [N-1:0]    cur_r, cur_l, cur_g;
    logic [N*AW-1:0] cur_a;
    logic [AW-1:0]   cur_addr;
    int              cur_idx;
    bit              cur_keep;
    bit              cur_rst;

    task automatic model_reset();
        m_last   = N - 1;
        m_locked = 1'b0;
        m_owner  = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    // Drive inputs for one cycle, then check everything visible in that cycle.
    task automatic apply(input logic [N-1:0] r, input logic [N-1:0] l,
                         input logic [N*AW-1:0] a, input bit rst);
        logic [N+AW-1:0] prev;
        logic [N-1:0]    dut_g;
        bit              dut_busy;
        bit              lock_cont;
        int              c;
        reset        = rst;
        bus.req      = r;
        bus.lock     = l;
        bus.req_addr = a;
        cur_r = r; cur_l = l; cur_a = a; cur_rst = rst;
        #2;
        // Owner with req and lock keeps the ROM; else first requester after m_last.
        cur_keep = m_locked && r[m_owner] && l[m_owner];
        cur_idx  = -1;
        if (cur_keep) begin
            cur_idx = m_owner;
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (cur_idx < 0 && r[c]) cur_idx = c;
            end
        end
        cur_g    = '0;
        cur_addr = '0;
        if (!rst && cur_idx >= 0) begin
            cur_g[cur_idx] = 1'b1;
            cur_addr       = a[cur_idx*AW +: AW];
        end
        prev = exp_q.pop_front();

        check_eq("gnt", bus.gnt, cur_g);
        check_eq("rom_addr", bus.rom_addr, cur_addr);
        check_eq("busy", bus.busy, m_locked);
        check_eq("fsm_state", bus.fsm_state, m_locked);
        check_eq("rd_valid", bus.rd_valid, prev[N+AW-1:AW]);
        if (rst || prev[N+AW-1:AW] == '0) check_eq("rd_data_zero", bus.rd_data, 0);
        else check_eq("rd_data", bus.rd_data, rom_mem[prev[AW-1:0]]);
        check_eq("gnt_onehot0", $onehot0(bus.gnt), 1);

        // Starvation bound: count grants to others that were not lock continuations.
        dut_g     = bus.gnt;
        dut_busy  = bus.busy;
        lock_cont = dut_busy && ((dut_g & r & l) != '0);
        for (int i = 0; i < N; i++) begin
            if (rst || !r[i] || dut_g[i]) begin
                wait_cnt[i] = 0;
            end else if (dut_g != '0 && !lock_cont) begin
                wait_cnt[i]++;
                check_eq("fair_wait", (wait_cnt[i] <= N - 1), 1);
            end
        end
    endtask

    // Advance the model across the rising edge and move to the next cycle.
    task automatic tick();
        if (cur_rst) begin
            model_reset();
            exp_q.push_back('0);
        end else begin
            exp_q.push_back({cur_g, cur_addr});
            if (cur_idx >= 0) begin
                m_last = cur_idx;
                if (!cur_keep && cur_l[cur_idx]) m_owner = cur_idx;
                m_locked = cur_keep || cur_l[cur_idx];
            end else begin
                m_locked = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver / sequences ----------------
    logic [N*AW-1:0] addrs;
    logic [N-1:0]    rr_seq [4];
    logic [N*AW-1:0] ra;
    logic [N-1:0]    rr, rl;

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = DW'($urandom);
        addrs        = {8'h30, 8'h20, 8'h10};
        reset        = 1'b1;
        bus.req      = '0;
        bus.lock     = '0;
        bus.req_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        exp_q.push_back('0);

        // Reset state
        apply(3'b111, 3'b000, addrs, 1'b1);
        check_eq("reset_gnt", bus.gnt, 3'b000);
        tick();

        // Round robin from index 0 with all requesting
        rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;
        for (int i = 0; i < 4; i++) begin
            apply(3'b111, 3'b000, addrs, 1'b0);
            check_eq("rr_gnt", bus.gnt, rr_seq[i]);
            if (i > 0) check_eq("rr_rd_valid", bus.rd_valid, rr_seq[i-1]);
            tick();
        end
        apply(3'b000, 3'b000, addrs, 1'b0);
        check_eq("rr_rd_valid_last", bus.rd_valid, 3'b001);
        tick();

        // Single requester 1 with address 8'h21
        apply(3'b010, 3'b000, {8'h30, 8'h21, 8'h10}, 1'b0);
        check_eq("single_gnt", bus.gnt, 3'b010);
        check_eq("single_addr", bus.rom_addr, 8'h21);
        tick();
        apply(3'b000, 3'b000, addrs, 1'b0);
        check_eq("single_rd_valid", bus.rd_valid, 3'b010);
        check_eq("single_rd_data", bus.rd_data, rom_mem[8'h21]);
        tick();

        // Lock held by requester 2 against competing requests
        for (int i = 0; i < 3; i++) begin
            apply(3'b111, 3'b100, addrs, 1'b0);
            check_eq("lock_gnt", bus.gnt, 3'b100);
            if (i > 0) check_eq("lock_busy", bus.busy, 1'b1);
            tick();
        end
        apply(3'b111, 3'b000, addrs, 1'b0);
        check_eq("unlock_gnt", bus.gnt, 3'b001);
        tick();
        apply(3'b000, 3'b000, addrs, 1'b0);
        check_eq("unlock_busy", bus.busy, 1'b0);
        tick();

        // Lock without request is ignored
        apply(3'b000, 3'b001, addrs, 1'b0);
        check_eq("lock_noreq_gnt", bus.gnt, 3'b000);
        tick();
        apply(3'b000, 3'b001, addrs, 1'b0);
        check_eq("lock_noreq_busy", bus.busy, 1'b0);
        tick();

        // Reset pulse while locked on requester 1 with a read in flight
        apply(3'b010, 3'b010, addrs, 1'b0);
        tick();
        apply(3'b010, 3'b010, addrs, 1'b0);
        check_eq("mid_lock_gnt", bus.gnt, 3'b010);
        tick();
        apply(3'b111, 3'b010, addrs, 1'b1);
        check_eq("mid_reset_gnt", bus.gnt, 3'b000);
        check_eq("mid_reset_addr", bus.rom_addr, 8'h00);
        tick();
        apply(3'b111, 3'b000, addrs, 1'b0);
        check_eq("post_reset_rd_valid", bus.rd_valid, 3'b000);
        check_eq("post_reset_busy", bus.busy, 1'b0);
        check_eq("post_reset_gnt", bus.gnt, 3'b001);
        tick();

        // Random traffic
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rr = N'($urandom_range(0, (1 << N) - 1));
            rl = '0;
            for (int i = 0; i < N; i++) rl[i] = ($urandom_range(0, 9) < 4);
            ra = {AW'($urandom), AW'($urandom), AW'($urandom)};
            apply(rr, rl, ra, ($urandom_range(0, 499) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3, meaning the number of renderers sharing one sprite ROM (index 0 = character, 1 = enemy, 2 = bullet).
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning the sprite ROM address width (16x16 sprite).
REQ-003 The block SHALL have parameter DATA_W, default 24, meaning the ROM word width (R[23:16], G[15:8], B[7:0]).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, N_REQ bits: per-requester read request, level.
REQ-007 The block SHALL have port lock, input, N_REQ bits: per-requester burst-hold request, meaningful only with its req bit.
REQ-008 The block SHALL have port req_addr, input, N_REQ*ADDR_W bits: requester i's address in slice [i*ADDR_W +: ADDR_W].
REQ-009 The block SHALL have port gnt, output, N_REQ bits: one-hot or zero, combinational, the requester served this cycle.
REQ-010 The block SHALL have port rom_addr, output, ADDR_W bits: address to the ROM, sampled by the ROM on the same rising edge.
REQ-011 The block SHALL have port rom_q, input, DATA_W bits: ROM output, valid one cycle after its address was presented.
REQ-012 The block SHALL have port rd_valid, output, N_REQ bits: registered one-hot, marks which requester rd_data belongs to.
REQ-013 The block SHALL have port rd_data, output, DATA_W bits: equals rom_q when any rd_valid bit is set, else 0.
REQ-014 The block SHALL have port busy, output, 1 bit: registered, 1 while a lock is held.

Function
REQ-015 Each cycle with req nonzero, gnt SHALL have exactly one bit set; with req zero, gnt SHALL be 0.
REQ-016 Unlocked arbitration SHALL be round-robin: search starts at index (last_ptr+1) mod N_REQ, first set req bit wins.
REQ-017 last_ptr SHALL update to the granted index on every cycle with a grant, and hold otherwise.
REQ-018 The state machine SHALL have two states, ARB and LOCKED, and SHALL move ARB->LOCKED when the granted requester has lock=1 in that cycle.
REQ-019 In LOCKED, the owner SHALL be granted whenever req[owner]=1, regardless of other requests.
REQ-020 The FSM SHALL move LOCKED->ARB, and arbitrate normally in that same cycle, when req[owner]=0 or lock[owner]=0.
REQ-021 lock with req=0 SHALL be ignored.
REQ-022 rom_addr SHALL be the granted requester's req_addr slice, or 0 when no grant.
REQ-023 rd_valid SHALL equal gnt delayed by exactly one clk (read latency 1 cycle), with no bubbles between back-to-back grants.
REQ-024 busy SHALL be 1 exactly in the cycles the FSM is in LOCKED.
REQ-025 Index wrap: after granting N_REQ-1, the search SHALL start at 0.

Reset
REQ-026 With reset=1 at a rising edge: FSM=ARB, last_ptr=N_REQ-1 (so index 0 has first priority), rd_valid=0, busy=0; gnt, rom_addr and rd_data SHALL be 0 while reset is high.
REQ-027 A read granted in the cycle before reset SHALL be discarded: rd_valid=0 in the cycle after reset is asserted.
REQ-028 Reset asserted mid-lock SHALL release the lock; the first post-reset grant follows REQ-026 priority.

Verification
REQ-029 Reset, then req=3'b111, lock=0 for 4 cycles -> gnt 001,010,100,001; rd_valid the same sequence shifted one cycle.
REQ-030 req=3'b010 with req_addr[1]=8'h21 -> gnt=010, rom_addr=8'h21; next cycle rd_valid=010, rd_data=rom_q.
REQ-031 Requester 2 granted with lock=1, requesters 0/1 requesting, for 3 cycles -> gnt=100 for 3 cycles, busy=1; lock[2] drops -> same cycle gnt=001, next cycle busy=0.
REQ-032 lock=3'b001, req=3'b000 -> gnt=000, busy stays 0.
REQ-033 Reset pulsed for 1 cycle while locked on requester 1 with a read in flight -> next cycle rd_valid=0, busy=0; with req=3'b111 the next grant is 001.
REQ-034 Random req/lock for 10k cycles -> gnt always one-hot or zero, rd_valid always equals gnt delayed one cycle, and no requester with req held waits more than N_REQ-1 unlocked grants.
